// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory arbiter: FSM states and owner codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant picker for the memory arbiter.
// MEM_ARB_RR_EN selects round-robin on collisions; otherwise data always wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic flush,
    input  logic last_owner,
    output logic gnt_valid,
    output logic gnt_owner
);

    logic i_ok;

    // A flushed fetch is stale, so it never competes for the memory.
    assign i_ok      = i_req & ~flush;
    assign gnt_valid = d_req | i_ok;

`ifdef MEM_ARB_RR_EN
    assign gnt_owner = (d_req & i_ok) ? ~last_owner : (d_req ? OWN_D : OWN_I);
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign gnt_owner         = d_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and MEM-stage data.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests (default: data priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_ctrl,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [2:0]    m_ctrl,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          stall_if,
    output logic          stall_mem
);

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          drop_q, drop_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;

    logic last_owner;
    logic gnt_valid;
    logic gnt_owner;

`ifdef MEM_ARB_RR_EN
    logic last_owner_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWN_I;
        end else if (state_q == ARB_IDLE && gnt_valid) begin
            last_owner_q <= gnt_owner;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_I;
`endif

    arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .flush      (flush),
        .last_owner (last_owner),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        drop_d    = drop_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ctrl_d    = ctrl_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                drop_d = 1'b0;
                if (gnt_valid) begin
                    owner_d = gnt_owner;
                    state_d = ARB_BUSY;
                    if (gnt_owner == OWN_D) begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        ctrl_d  = d_ctrl;
                    end else begin
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        ctrl_d  = 3'b000;
                    end
                end
            end
            ARB_BUSY: begin
                if (flush && owner_q == OWN_I) begin
                    drop_d = 1'b1;
                end
                if (m_ack) begin
                    state_d = ARB_RESP;
                    // A flush landing on the ack cycle must already block the capture.
                    if (owner_q == OWN_I && !drop_q && !flush) begin
                        i_rdata_d = m_rdata;
                    end
                    if (owner_q == OWN_D && !we_q) begin
                        d_rdata_d = m_rdata;
                    end
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
                drop_d  = 1'b0;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_D;
            drop_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ctrl_q    <= 3'b000;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            drop_q    <= drop_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ctrl_q    <= ctrl_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // m_req is decoded from state so an asynchronous reset drops it at once.
    assign m_req   = (state_q == ARB_BUSY);
    assign m_we    = we_q;
    assign m_addr  = addr_q;
    assign m_wdata = wdata_q;
    assign m_ctrl  = ctrl_q;

    // A flush arriving in the response cycle still suppresses the fetch pulse.
    assign i_valid = (state_q == ARB_RESP) && (owner_q == OWN_I) && !drop_q && !flush;
    assign d_valid = (state_q == ARB_RESP) && (owner_q == OWN_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    assign stall_if  = i_req & ~i_valid;
    assign stall_mem = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: grant table, directed corner sequences and
// randomized traffic checked against a timestamp-based transaction model.
module tb_mem_arbiter;

    localparam bit TB_I = 1'b0;
    localparam bit TB_D = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [2:0]  d_ctrl = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_ctrl;
    logic [31:0] m_rdata = '0;
    logic        m_ack = 1'b0;
    logic        stall_if;
    logic        stall_mem;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ctrl(d_ctrl),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ctrl(m_ctrl),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    int checks = 0;
    int failures = 0;

    // Transaction model: an access granted in cycle mT holds m_req until the ack cycle mA,
    // responds in mA+1 and the arbiter is free again from mA+2.
    int          cyc = 0;
    int          mT, mA, midle_from, mcnt, ack_dly;
    bit          ma, macked, mdrop, mown, mwe, mlast, junk;
    logic [31:0] maddr, mwdata, exp_ir, exp_dr;
    logic [2:0]  mctrl;

    bit          saw_mreq, saw_iv, saw_dv, saw_sif, saw_smem, saw_mwe;
    logic [31:0] saw_maddr, saw_mwdata;

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic model_reset();
        ma = 0; macked = 0; mdrop = 0; mlast = TB_I;
        exp_ir = '0; exp_dr = '0;
        midle_from = cyc; mcnt = 0;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_m_req"}, m_req, 0);
        chk({pfx, "_m_we"}, m_we, 0);
        chk({pfx, "_m_addr"}, m_addr, 0);
        chk({pfx, "_m_wdata"}, m_wdata, 0);
        chk({pfx, "_m_ctrl"}, m_ctrl, 0);
        chk({pfx, "_i_rdata"}, i_rdata, 0);
        chk({pfx, "_i_valid"}, i_valid, 0);
        chk({pfx, "_d_rdata"}, d_rdata, 0);
        chk({pfx, "_d_valid"}, d_valid, 0);
    endtask

    // One clock cycle: check at the falling edge, drive memory, advance the model.
    task automatic step();
        bit e_mreq, e_resp, e_iv, e_dv, iok, g, g_own;
        @(negedge clk);
        e_mreq = ma && (cyc > mT) && !macked;
        e_resp = ma && macked && (cyc == mA + 1);
        e_iv   = e_resp && (mown == TB_I) && !mdrop && !flush;
        e_dv   = e_resp && (mown == TB_D);
        chk("m_req", m_req, e_mreq);
        if (e_mreq) begin
            chk("m_addr", m_addr, maddr);
            chk("m_we", m_we, mwe);
            chk("m_ctrl", m_ctrl, mctrl);
            if (mwe) chk("m_wdata", m_wdata, mwdata);
        end
        chk("i_valid", i_valid, e_iv);
        chk("d_valid", d_valid, e_dv);
        chk("i_rdata", i_rdata, exp_ir);
        chk("d_rdata", d_rdata, exp_dr);
        chk("stall_if", stall_if, i_req && !e_iv);
        chk("stall_mem", stall_mem, d_req && !e_dv);
        saw_mreq = m_req; saw_iv = i_valid; saw_dv = d_valid;
        saw_sif = stall_if; saw_smem = stall_mem;
        saw_mwe = m_we; saw_maddr = m_addr; saw_mwdata = m_wdata;

        if (m_req) begin
            mcnt++;
            m_ack = (mcnt >= ack_dly);
        end else begin
            mcnt = 0;
            m_ack = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        m_rdata = (m_req && m_ack) ? memval(m_addr) : $urandom();

        if (ma && (cyc > mT) && !macked) begin
            if (flush && mown == TB_I) mdrop = 1;
            if (m_ack) begin
                macked = 1; mA = cyc;
                if (mown == TB_I && !mdrop) exp_ir = memval(maddr);
                if (mown == TB_D && !mwe) exp_dr = memval(maddr);
            end
        end else if (e_resp) begin
            ma = 0; midle_from = cyc + 1;
        end else if (!ma && cyc >= midle_from) begin
            iok = i_req && !flush;
            g = d_req || iok;
`ifdef MEM_ARB_RR_EN
            if (d_req && iok) g_own = (mlast == TB_I) ? TB_D : TB_I;
            else g_own = d_req ? TB_D : TB_I;
`else
            g_own = d_req ? TB_D : TB_I;
`endif
            if (g) begin
                ma = 1; mT = cyc; macked = 0; mdrop = 0; mown = g_own; mlast = g_own;
                if (g_own == TB_D) begin
                    maddr = d_addr; mwe = d_we; mwdata = d_wdata; mctrl = d_ctrl;
                end else begin
                    maddr = i_addr; mwe = 0; mwdata = '0; mctrl = 3'b000;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(saw_iv || saw_dv) && n < budget);
        chk("valid_within_budget", 32'(saw_iv || saw_dv), 1);
    endtask

    typedef struct {
        bit          d_req, i_req, flush, d_we;
        bit          gnt;
        logic [31:0] addr;
        bit          we;
    } vec_t;

    initial begin
        vec_t tv[8];
        bit [3:0] mreq_h, iv_h, sif_h;
        int n, nreq, nv;
        bit ok;

        ack_dly = 1; junk = 0; mT = 0; mA = 0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        model_reset();

        // Fetch only
        i_req = 1; i_addr = 32'h0000_0010; ack_dly = 2;
        for (int k = 0; k < 4; k++) begin
            step();
            mreq_h[k] = saw_mreq; iv_h[k] = saw_iv; sif_h[k] = saw_sif;
        end
        chk("fetch_mreq_window", 32'(mreq_h), 32'(4'b0110));
        chk("fetch_ivalid_pulse", 32'(iv_h), 32'(4'b1000));
        chk("fetch_stall_if", 32'(sif_h), 32'(4'b0111));
        chk("fetch_rdata", i_rdata, 32'h0050_0093);
        i_req = 0;
        step();

        // Grant decisions from IDLE: {d_req, i_req, flush, d_we, gnt, addr, we}
        tv[0] = '{0, 0, 0, 0, 0, 32'h0,  0};
        tv[1] = '{0, 1, 0, 0, 1, 32'h40, 0};
        tv[2] = '{1, 0, 0, 0, 1, 32'h80, 0};
        tv[3] = '{0, 1, 1, 0, 0, 32'h0,  0};
        tv[4] = '{1, 1, 1, 1, 1, 32'h80, 1};
`ifdef MEM_ARB_RR_EN
        tv[5] = '{1, 1, 0, 0, 1, 32'h40, 0};
        tv[6] = '{1, 1, 0, 0, 1, 32'h80, 0};
        tv[7] = '{1, 1, 0, 0, 1, 32'h40, 0};
`else
        tv[5] = '{1, 1, 0, 0, 1, 32'h80, 0};
        tv[6] = '{1, 1, 0, 0, 1, 32'h80, 0};
        tv[7] = '{1, 1, 0, 0, 1, 32'h80, 0};
`endif
        for (int r = 0; r < 8; r++) begin
            d_req = tv[r].d_req; i_req = tv[r].i_req; flush = tv[r].flush; d_we = tv[r].d_we;
            i_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h1234_0000 + r; d_ctrl = 3'(r);
            ack_dly = 1;
            step();
            flush = 0;
            if (!tv[r].gnt) begin
                d_req = 0; i_req = 0;
            end
            step();
            chk($sformatf("tv%0d_mreq", r), saw_mreq, tv[r].gnt);
            if (tv[r].gnt) begin
                chk($sformatf("tv%0d_addr", r), saw_maddr, tv[r].addr);
                chk($sformatf("tv%0d_we", r), saw_mwe, tv[r].we);
                wait_valid(10);
                d_req = 0; i_req = 0;
                step();
            end
            step();
        end

        // Flush mid-fetch: the dropped fetch must not deliver, the new PC must
        i_req = 1; i_addr = 32'h300; ack_dly = 3;
        step();
        step();
        flush = 1;
        step();
        flush = 0; i_addr = 32'h400;
        chk("flush_rdata_held", i_rdata, memval(32'h40));
        wait_valid(30);
        chk("flush_new_pc_rdata", i_rdata, memval(32'h400));
        i_req = 0;
        step(); step();

        // Store leaves d_rdata alone
        d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_ctrl = 3'b010; ack_dly = 3;
        step();
        step();
        chk("store_m_we", saw_mwe, 1);
        chk("store_m_wdata", saw_mwdata, 32'hDEAD_BEEF);
        wait_valid(10);
        chk("store_d_rdata_kept", d_rdata, memval(32'h80));
        d_req = 0; d_we = 0;
        step();

        // Slow memory: ten busy cycles with stable fields and both stalls high
        d_req = 1; d_addr = 32'h500; d_ctrl = 3'b100; ack_dly = 10;
        step();
        i_req = 1; i_addr = 32'h600;
        n = 0; nreq = 0; ok = 1;
        do begin
            step();
            n++;
            if (saw_mreq) begin
                nreq++;
                if (!(saw_sif && saw_smem && saw_maddr == 32'h500)) ok = 0;
            end
        end while (!saw_dv && n < 40);
        chk("slow_busy_cycles", nreq, 10);
        chk("slow_stalls_fields", 32'(ok), 1);
        chk("slow_d_rdata", d_rdata, memval(32'h500));
        d_req = 0;
        ack_dly = 2;
        wait_valid(20);
        chk("slow_then_fetch", i_rdata, memval(32'h600));
        i_req = 0;
        step();

        // Asynchronous reset while BUSY
        d_req = 1; d_addr = 32'h700; ack_dly = 8;
        step(); step(); step();
        chk("rst_busy_before", m_req, 1);
        #2;
        rst_n = 0;
        #1;
        check_reset_vals("rst_busy");
        d_req = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
        nv = 0;
        repeat (6) begin
            step();
            if (saw_iv || saw_dv) nv++;
        end
        chk("rst_no_valid_after", nv, 0);

        // Randomized traffic
        junk = 1;
        for (int c = 0; c < 1500; c++) begin
            if (d_req && saw_dv) d_req = 0;
            else if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom(); d_wdata = $urandom(); d_ctrl = 3'($urandom_range(0, 7));
            end
            if (i_req && saw_iv) i_req = 0;
            else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = $urandom();
            end
            flush = ($urandom_range(0, 9) == 0);
            if (flush && i_req) i_addr = $urandom();
            ack_dly = $urandom_range(1, 4);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its MEM-stage data port.
- Sequences each access with a 3-state FSM and routes the memory response back to the requester that issued it.
- Produces `stall_if` and `stall_mem` so the pipeline holds its IF/ID and EX/MEM registers while an access is outstanding.
- Honours the pipeline's branch/jump `flush` by discarding an in-flight fetch.

Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  pipeline flush; cancels the fetch in progress.
- `i_req`  in  1  fetch request, level, held until `i_valid`.
- `i_addr`  in  AW  fetch address (PC).
- `i_rdata`  out  DW  fetched instruction.
- `i_valid`  out  1  one-cycle fetch-complete pulse.
- `d_req`  in  1  data request, level, held until `d_valid`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  AW  data address (ALU result).
- `d_wdata`  in  DW  store data.
- `d_ctrl`  in  3  `dm_ctrl` width/sign code, passed through to memory.
- `d_rdata`  out  DW  load data.
- `d_valid`  out  1  one-cycle data-complete pulse (loads and stores).
- `m_req`  out  1  memory request, held until `m_ack`.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  AW  memory address.
- `m_wdata`  out  DW  memory write data.
- `m_ctrl`  out  3  memory `dm_ctrl`.
- `m_rdata`  in  DW  memory read data, valid in the `m_ack` cycle.
- `m_ack`  in  1  memory completion.
- `stall_if`  out  1  `i_req & ~i_valid`, combinational.
- `stall_mem`  out  1  `d_req & ~d_valid`, combinational.

Behaviour:
- Reset: state IDLE. `m_req`, `m_we`, `m_addr`, `m_wdata`, `m_ctrl`, `i_rdata`, `i_valid`, `d_rdata`, `d_valid` all 0. `owner` = D, `drop` = 0.
- Reset asserted mid-access: FSM returns to IDLE immediately and `m_req` drops asynchronously; the memory tolerates an abandoned request.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Sample requests.
  - If `d_req`: grant D.
  - Else if `i_req & ~flush`: grant I.
  - On grant: register owner, address, write data, control and `m_we` (I grant forces `m_we=0`, `m_ctrl=0`), then go to BUSY.
  - No grant: stay in IDLE.
- BUSY:
  - `m_req=1` with the captured fields held stable.
  - On `m_ack`: capture `m_rdata` into the owner's rdata register and go to RESP.
  - No timeout.
- RESP:
  - Owner's valid = 1 for exactly this cycle; go to IDLE.
  - Requests are not sampled in RESP, so the requester drops `req` on the same edge.
- Latency: request seen in IDLE at cycle T → `m_req` at T+1 → ack at T+k (k≥1) → valid at T+k+1 → IDLE at T+k+2. Minimum 3 cycles per access; back-to-back grants are 3 cycles apart.
- Store: `d_valid` pulses; `d_rdata` keeps its previous value.
- Non-owner outputs: the non-owner's rdata and valid are unchanged/0.
- Flush:
  - In IDLE: suppresses an I grant only; a D grant proceeds.
  - In BUSY or RESP with owner I: sets `drop`. The access completes on the memory side, but `i_valid` stays 0 and `i_rdata` is not updated. `drop` clears on entry to IDLE.
  - Data accesses are never affected by flush.
- Simultaneous `d_req` and `i_req` in IDLE: D wins (default build).
- `m_ack` outside BUSY: ignored.

Optional Feature:
- Macro: `MEM_ARB_RR_EN`.
- Defined: round-robin. A 1-bit `last_owner` register, reset to I. On a simultaneous request, the requester that is not `last_owner` wins; a single request is always granted.
- Undefined: fixed data priority as above, and no `last_owner` register is built.

Decomposition:
- Package `mem_arb_pkg`:
  - state encoding `ARB_IDLE`=2'd0, `ARB_BUSY`=2'd1, `ARB_RESP`=2'd2;
  - owner constants `OWN_I`=1'b0, `OWN_D`=1'b1.
- Sub-module `arb_pick`: combinational grant picker.
  - Inputs: `i_req`, `d_req`, `flush`, `last_owner`.
  - Outputs: `gnt_valid`, `gnt_owner`.
  - Isolates the priority vs round-robin logic under `MEM_ARB_RR_EN`.
- The FSM, capture registers and response routing stay in `mem_arbiter`.

Test Plan:
- Fetch only:
  - Stimulus: `i_req=1`, `i_addr=0x0000_0010`; memory returns `m_rdata=0x0050_0093` with `m_ack` in the 2nd BUSY cycle.
  - Response: `m_req` at T+1..T+2, `i_valid` pulse at T+3 with `i_rdata=0x0050_0093`; `stall_if=1` T..T+2.
- Load vs fetch collision:
  - Stimulus: `d_req` (load, `d_addr=0x100`, `d_ctrl=3'b000`) and `i_req` both high at T.
  - Response: D granted first (`m_addr=0x100`, `m_we=0`); I granted at the next IDLE.
  - With `MEM_ARB_RR_EN` and reset `last_owner`=I: D first, then I; repeated collision alternates D, I, D, I.
- Store:
  - Stimulus: `d_we=1`, `d_addr=0x200`, `d_wdata=0xDEAD_BEEF`.
  - Response: `m_we=1`, `m_wdata=0xDEAD_BEEF` held until ack; `d_valid` pulses; `d_rdata` unchanged.
- Flush mid-fetch:
  - Stimulus: `flush=1` for one cycle while owner I is in BUSY.
  - Response: memory access completes, `i_valid` stays 0, `i_rdata` unchanged; the next `i_req` (new PC) is served normally.
- Slow memory:
  - Stimulus: `m_ack` delayed 10 cycles.
  - Response: `m_req` and all fields stable for 10 cycles; `stall_mem`/`stall_if` held high throughout.
- Reset during BUSY:
  - Stimulus: `rst_n=0` asynchronously.
  - Response: `m_req` → 0 without a clock edge; all outputs at reset values; no valid pulse after release.
